// File: rtl/mux16_rr_sched_if.sv
// Bus between the 16-requester round-robin scheduler and its requesters / mux.
// master drives requests, release and mux data; slave is the scheduler.
interface mux16_rr_sched_if;
   logic [15:0] req;
   logic        done;
   logic        mux_out;
   logic [3:0]  sel;
   logic [15:0] gnt;
   logic        gnt_valid;
   logic        bit_q;
   logic        bit_vld;
   logic        timeout;

   modport master (
      output req, done, mux_out,
      input  sel, gnt, gnt_valid, bit_q, bit_vld, timeout
   );

   modport slave (
      input  req, done, mux_out,
      output sel, gnt, gnt_valid, bit_q, bit_vld, timeout
   );
endinterface

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduler sharing a 16:1 single-bit mux; registers the mux output.
// Optional grant-tenure timeout enabled by defining MUX16_SCHED_TIMEOUT_EN.
module mux16_rr_sched #(
   parameter int unsigned HOLD_MAX = 8
) (
   input logic             clk,
   input logic             rst_n,
   mux16_rr_sched_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

   if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
      $error("HOLD_MAX must be in 1..255");
   end

   state_e      state_q, state_d;
   logic [3:0]  ptr_q, ptr_d;
   logic [3:0]  sel_q, sel_d;
   logic [15:0] gnt_q, gnt_d;
   logic        gnt_valid_q, gnt_valid_d;
   logic        data_q, data_d;
   logic        data_vld_q, data_vld_d;

   logic [3:0]  winner;
   logic [3:0]  idx;
   logic        found;
   logic        cnt_hit;
   logic        release_hit;

`ifdef MUX16_SCHED_TIMEOUT_EN
   logic [7:0]  cnt_q, cnt_d;
   logic        timeout_q, timeout_d;

   assign cnt_hit     = (state_q == StGrant) && (cnt_q == 8'(HOLD_MAX - 1));
   assign bus.timeout = timeout_q;
`else
   assign cnt_hit     = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   // Search starts just above the last owner; i = 16 wraps back onto it, giving it lowest priority.
   always_comb begin
      winner = ptr_q;
      idx    = ptr_q;
      found  = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         idx = ptr_q + 4'(i);
         if (!found && bus.req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end

   assign release_hit = bus.done || !bus.req[sel_q] || cnt_hit;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      gnt_d       = gnt_q;
      gnt_valid_d = gnt_valid_q;
      data_d      = bus.mux_out;
      data_vld_d  = gnt_valid_q;
`ifdef MUX16_SCHED_TIMEOUT_EN
      cnt_d       = cnt_q;
      timeout_d   = 1'b0;
`endif
      unique case (state_q)
         StIdle, StRelease: begin
            if (found) begin
               state_d     = StGrant;
               ptr_d       = winner;
               sel_d       = winner;
               gnt_d       = 16'h1 << winner;
               gnt_valid_d = 1'b1;
`ifdef MUX16_SCHED_TIMEOUT_EN
               cnt_d       = 8'd0;
`endif
            end else begin
               state_d     = StIdle;
               gnt_d       = 16'h0;
               gnt_valid_d = 1'b0;
            end
         end
         StGrant: begin
`ifdef MUX16_SCHED_TIMEOUT_EN
            cnt_d = cnt_q + 8'd1;
`endif
            if (release_hit) begin
               state_d     = StRelease;
               gnt_d       = 16'h0;
               gnt_valid_d = 1'b0;
`ifdef MUX16_SCHED_TIMEOUT_EN
               timeout_d   = cnt_hit;
`endif
            end
         end
         default: begin
            state_d     = StIdle;
            gnt_d       = 16'h0;
            gnt_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= 4'hf;
         sel_q       <= 4'h0;
         gnt_q       <= 16'h0;
         gnt_valid_q <= 1'b0;
         data_q      <= 1'b0;
         data_vld_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         gnt_q       <= gnt_d;
         gnt_valid_q <= gnt_valid_d;
         data_q      <= data_d;
         data_vld_q  <= data_vld_d;
      end
   end

`ifdef MUX16_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
`endif

   assign bus.sel       = sel_q;
   assign bus.gnt       = gnt_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.bit_q     = data_q;
   assign bus.bit_vld   = data_vld_q;

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched: directed scenarios plus random traffic
// checked against a cycle-level reference model of the scheduling rules.
module tb_mux16_rr_sched;

   localparam int unsigned HM = 4;
`ifdef MUX16_SCHED_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   mux16_rr_sched_if bus ();

   mux16_rr_sched #(.HOLD_MAX(HM)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // Reference model: owner index (-1 = nobody), last granted index, tenure.
   int   m_owner;
   int   m_last;
   int   m_sel;
   int   m_ten;
   logic m_bit_q;
   logic m_bit_vld;
   logic m_timeout;

   function automatic int pick(logic [15:0] r, int last);
      for (int k = 1; k <= 16; k++) begin
         if (r[(last + k) % 16]) return (last + k) % 16;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner   = -1;
      m_last    = 15;
      m_sel     = 0;
      m_ten     = 0;
      m_bit_q   = 1'b0;
      m_bit_vld = 1'b0;
      m_timeout = 1'b0;
   endtask

   task automatic model_step();
      logic hit;
      m_timeout = 1'b0;
      m_bit_q   = bus.mux_out;
      m_bit_vld = (m_owner >= 0);
      if (m_owner >= 0) begin
         hit = TO_EN && (m_ten == int'(HM) - 1);
         if (bus.done || !bus.req[m_owner] || hit) begin
            m_timeout = hit;
            m_owner   = -1;
         end else begin
            m_ten++;
         end
      end else if (bus.req != 16'h0) begin
         m_owner = pick(bus.req, m_last);
         m_last  = m_owner;
         m_sel   = m_owner;
         m_ten   = 0;
      end
   endtask

   function automatic logic [23:0] exp_vec();
      logic [15:0] g;
      g = (m_owner >= 0) ? (16'h1 << m_owner) : 16'h0;
      return {g, 4'(m_sel), (m_owner >= 0), m_bit_q, m_bit_vld, m_timeout};
   endfunction

   function automatic logic [23:0] act_vec();
      return {bus.gnt, bus.sel, bus.gnt_valid, bus.bit_q, bus.bit_vld, bus.timeout};
   endfunction

   task automatic step();
      bus.mux_out = 1'($urandom_range(0, 1));
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic apply_reset();
      rst_n    = 1'b0;
      bus.req  = 16'h0;
      bus.done = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++;
      if (act_vec() !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_values: got %h expected %h", act_vec(), 24'h0);
      end
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL reset_idle_model: got %h expected %h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_single_request();
      apply_reset();
      bus.req = 16'h0010;
      step();
      n_checks++;
      if (bus.gnt !== 16'h0010 || bus.sel !== 4'd4 || bus.gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL single_grant: got gnt=%h sel=%0d vld=%b expected gnt=0010 sel=4 vld=1",
                  bus.gnt, bus.sel, bus.gnt_valid);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (bus.bit_q !== bus.mux_out || bus.bit_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL single_data_lag: got bit_q=%b vld=%b expected bit_q=%b vld=1",
                     bus.bit_q, bus.bit_vld, bus.mux_out);
         end
      end
      bus.req = 16'h0;
      step();
      n_checks++;
      if (bus.gnt !== 16'h0 || bus.gnt_valid !== 1'b0 || bus.sel !== 4'd4) begin
         n_fail++;
         $display("FAIL single_release: got gnt=%h vld=%b sel=%0d expected gnt=0 vld=0 sel=4",
                  bus.gnt, bus.gnt_valid, bus.sel);
      end
      step();
      n_checks++;
      if (act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL single_idle_model: got %h expected %h", act_vec(), exp_vec());
      end
   endtask

   task automatic test_round_robin();
      logic [15:0] e;
      apply_reset();
      bus.req = 16'hffff;
      for (int k = 0; k < 17; k++) begin
         e = 16'h1 << (k % 16);
         step();
         n_checks++;
         if (bus.gnt !== e || bus.sel !== 4'(k % 16) || bus.gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_grant[%0d]: got gnt=%h sel=%0d expected gnt=%h sel=%0d",
                     k, bus.gnt, bus.sel, e, k % 16);
         end
         bus.done = 1'b1;
         step();
         bus.done = 1'b0;
         n_checks++;
         if (bus.gnt !== 16'h0 || bus.gnt_valid !== 1'b0 || bus.sel !== 4'(k % 16)) begin
            n_fail++;
            $display("FAIL rr_dead[%0d]: got gnt=%h vld=%b sel=%0d expected gnt=0 vld=0 sel=%0d",
                     k, bus.gnt, bus.gnt_valid, bus.sel, k % 16);
         end
      end
      bus.req = 16'h0;
      step();
   endtask

   task automatic test_wrap();
      int order [3] = '{15, 0, 1};
      logic [15:0] e;
      apply_reset();
      bus.req = 16'h4000;
      step();
      n_checks++;
      if (bus.sel !== 4'd14) begin
         n_fail++;
         $display("FAIL wrap_setup: got sel=%0d expected sel=14", bus.sel);
      end
      bus.req = 16'h0;
      step();
      step();
      bus.req = 16'h8003;
      for (int i = 0; i < 3; i++) begin
         e = 16'h1 << order[i];
         step();
         n_checks++;
         if (bus.gnt !== e || bus.sel !== 4'(order[i])) begin
            n_fail++;
            $display("FAIL wrap_order[%0d]: got gnt=%h sel=%0d expected gnt=%h sel=%0d",
                     i, bus.gnt, bus.sel, e, order[i]);
         end
         bus.done = 1'b1;
         step();
         bus.done = 1'b0;
      end
      bus.req = 16'h0;
      step();
   endtask

   task automatic test_req_drop();
      apply_reset();
      bus.req = 16'h0020;
      step();
      bus.req = 16'h0108;
      step();
      n_checks++;
      if (bus.gnt_valid !== 1'b0 || bus.gnt !== 16'h0) begin
         n_fail++;
         $display("FAIL drop_release: got vld=%b gnt=%h expected vld=0 gnt=0",
                  bus.gnt_valid, bus.gnt);
      end
      step();
      n_checks++;
      if (bus.sel !== 4'd8 || bus.gnt !== 16'h0100) begin
         n_fail++;
         $display("FAIL drop_next: got sel=%0d gnt=%h expected sel=8 gnt=0100", bus.sel, bus.gnt);
      end
      bus.req = 16'h0009;
      step();
      step();
      n_checks++;
      if (bus.sel !== 4'd0 || bus.gnt !== 16'h0001) begin
         n_fail++;
         $display("FAIL drop_wrap: got sel=%0d gnt=%h expected sel=0 gnt=0001", bus.sel, bus.gnt);
      end
      bus.req = 16'h0;
      step();
   endtask

   task automatic test_timeout();
      int hi;
      int pulses;
      apply_reset();
      bus.req = 16'h0040;
      step();
      hi     = 1;
      pulses = 0;
`ifdef MUX16_SCHED_TIMEOUT_EN
      for (int c = 0; c < 300; c++) begin
         step();
         if (bus.timeout === 1'b1) pulses++;
         if (bus.gnt_valid !== 1'b1) break;
         hi++;
      end
      n_checks++;
      if (hi != int'(HM) || pulses != 1) begin
         n_fail++;
         $display("FAIL timeout_tenure: got %0d cycles %0d pulses expected %0d cycles 1 pulse",
                  hi, pulses, HM);
      end
      step();
      n_checks++;
      if (bus.gnt !== 16'h0040 || bus.timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_regrant: got gnt=%h to=%b expected gnt=0040 to=0",
                  bus.gnt, bus.timeout);
      end
      for (int i = 0; i < int'(HM) - 1; i++) step();
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      n_checks++;
      if (bus.timeout !== 1'b1 || bus.gnt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_with_done: got to=%b vld=%b expected to=1 vld=0",
                  bus.timeout, bus.gnt_valid);
      end
      step();
      n_checks++;
      if (bus.timeout !== 1'b0 || bus.gnt_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL timeout_single_pulse: got to=%b vld=%b expected to=0 vld=1",
                  bus.timeout, bus.gnt_valid);
      end
`else
      for (int c = 0; c < 110; c++) begin
         step();
         if (bus.timeout !== 1'b0) pulses++;
         if (bus.gnt_valid === 1'b1) hi++;
      end
      n_checks++;
      if (hi != 111 || pulses != 0 || bus.gnt !== 16'h0040) begin
         n_fail++;
         $display("FAIL no_timeout_hold: got %0d cycles %0d pulses gnt=%h expected 111 0 0040",
                  hi, pulses, bus.gnt);
      end
`endif
      bus.req = 16'h0;
      step();
      step();
   endtask

   task automatic test_async_reset();
      apply_reset();
      bus.req = 16'h0200;
      step();
      step();
      n_checks++;
      if (bus.gnt !== 16'h0200 || bus.sel !== 4'd9 || bus.bit_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL areset_setup: got gnt=%h sel=%0d bv=%b expected gnt=0200 sel=9 bv=1",
                  bus.gnt, bus.sel, bus.bit_vld);
      end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (bus.gnt !== 16'h0 || bus.sel !== 4'd0 || bus.bit_vld !== 1'b0 ||
          bus.gnt_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL areset_async: got gnt=%h sel=%0d bv=%b vld=%b expected all zero",
                  bus.gnt, bus.sel, bus.bit_vld, bus.gnt_valid);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step();
      n_checks++;
      if (bus.gnt !== 16'h0200 || bus.sel !== 4'd9 || act_vec() !== exp_vec()) begin
         n_fail++;
         $display("FAIL areset_restart: got %h expected %h", act_vec(), exp_vec());
      end
      bus.req = 16'h0;
      step();
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 3))
               0:       bus.req = 16'h0;
               1:       bus.req = 16'h1 << $urandom_range(0, 15);
               default: bus.req = 16'($urandom);
            endcase
         end
         bus.done = ($urandom_range(0, 4) == 0);
         step();
         n_checks++;
         if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h expected %h", c, act_vec(), exp_vec());
         end
      end
      bus.done = 1'b0;
      bus.req  = 16'h0;
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      bus.req     = 16'h0;
      bus.done    = 1'b0;
      bus.mux_out = 1'b0;
      model_reset();
      test_reset();
      test_single_request();
      test_round_robin();
      test_wrap();
      test_req_drop();
      test_timeout();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/mux16_rr_sched.md
# mux16_rr_sched

Round-robin scheduler that shares the 16:1 single-bit multiplexer among 16 requesters. It arbitrates `req[15:0]`, drives the mux select `sel[3:0]` and a one-hot grant, and holds each grant until the owner signals `done` or drops its request. It also registers the mux output for the current owner. It sits directly in front of the `mux_16` instance: `sel` feeds the mux select, and the mux output returns on `mux_out`.

## Interface
- `HOLD_MAX`, 8: maximum grant tenure in cycles; legal range 1..255. Used only when the timeout feature is compiled in.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 16: request vector; bit k = requester k wants the mux.
- `done` input 1: one-cycle release pulse from the current owner; ignored when no grant is active.
- `mux_out` input 1: output of the 16:1 mux.
- `sel` output 4: mux select; binary index of the current or last owner.
- `gnt` output 16: one-hot grant; all zero when no grant is active.
- `gnt_valid` output 1: high while a grant is active.
- `bit_q` output 1: `mux_out` registered, qualified by `bit_vld`.
- `bit_vld` output 1: high the cycle after each cycle with `gnt_valid` = 1.
- `timeout` output 1: one-cycle pulse on a forced release; tied to 0 when the timeout feature is compiled out.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- **IDLE:** if `req` ≠ 0, choose a winner and go to GRANT. Otherwise stay in IDLE.
- **Winner selection:** the first set `req` bit, searching upward and cyclically from `ptr+1` mod 16.
- `ptr` is a 4-bit register holding the last granted index.
- **On entering GRANT:** `sel`, `gnt` and `ptr` load the winner, and `gnt_valid` goes to 1.
- **GRANT:** leave for RELEASE when any of these holds:
  - `done` = 1;
  - `req[sel]` = 0;
  - with the macro: the tenure counter reaches `HOLD_MAX`-1.
- **RELEASE:** one dead cycle with `gnt` = 0 and `gnt_valid` = 0. `sel` holds its value so the mux sees no glitch. Then:
  - if `req` ≠ 0, arbitrate as in IDLE and go directly to GRANT;
  - otherwise go to IDLE.
- **Fairness:** the just-released owner has the lowest priority in the next arbitration. If it is the only requester, it is re-granted.
- **Data capture:** `bit_q` <= `mux_out` every cycle. `bit_vld` <= `gnt_valid`.
- Other `req` bits changing during GRANT have no effect until the next arbitration.

## Timing
- **Reset values:** state = IDLE, `ptr` = 15 (so the first search starts at index 0), `sel` = 0, `gnt` = 0, `gnt_valid` = 0, `bit_q` = 0, `bit_vld` = 0, `timeout` = 0, tenure counter = 0.
- **Request to grant:** 1 cycle from IDLE. `req` is sampled at edge N, and `gnt`/`sel` are valid after edge N.
- **Release to next grant:** 2 edges. Release is detected at edge N, the FSM is in RELEASE during N..N+1, and the new grant is active after edge N+1.
- **Data latency:** 1 cycle. `bit_q` after edge N equals `mux_out` sampled at edge N.
- **Simultaneous `done` and timeout:** a single release; `timeout` pulses.
- **`done` in IDLE or RELEASE:** ignored.
- **`rst_n` low mid-grant:** all outputs go to their reset values immediately (asynchronously). Arbitration restarts from index 0 after reset is released.

## Configuration
- **`MUX16_SCHED_TIMEOUT_EN` defined:**
  - an 8-bit tenure counter clears on entry to GRANT and increments each cycle in GRANT;
  - at count `HOLD_MAX`-1 the grant is forced into RELEASE and `timeout` pulses for one cycle;
  - with `HOLD_MAX` = 1, every grant lasts exactly 1 cycle.
- **Macro not defined:**
  - the counter is not present and `timeout` is constant 0;
  - a grant lasts until `done` is asserted or `req[sel]` drops.

## Test plan
- **Reset then single request:** `req` = 16'h0010 → one cycle later `gnt` = 16'h0010, `sel` = 4, `gnt_valid` = 1; `bit_q` follows `mux_out` with 1-cycle lag.
- **Round robin, all requesting:** `req` = 16'hFFFF, `done` pulsed each grant → grant order 0,1,2,…,15,0. Every grant is separated by one RELEASE cycle with `gnt` = 0 and `sel` held.
- **Wrap priority:** last owner 14, then `req` = 16'h8003 → next grant is 15, then 0, then 1.
- **Request drop:** owner 5 deasserts `req[5]` without `done` → RELEASE the next cycle. The new winner is the lowest set index above 5 (cyclically).
- **Timeout (macro on, `HOLD_MAX` = 4):** owner holds `req` with no `done` → `gnt_valid` high for exactly 4 cycles and `timeout` pulses once. With the macro off, the grant persists for 100+ cycles.
- **Async reset mid-grant:** `rst_n` low while owner 9 holds the grant → `gnt` = 0, `sel` = 0, `bit_vld` = 0 without waiting for a clock edge. After release with `req` = 16'h0200, the next grant is 9.
